mem_seq_ctrl: RTL and testbench
===============================

// Module: mem_seq_ctrl
// PURPOSE
//  Parametrised memory-transaction sequencer. The main control FSM issues one request (op, addr, wdata)
//  and receives a done pulse. The block runs the whole bus sequence: word, byte or indirect
//  (pointer-fetch) access, with a response watchdog and alignment checking.
//  It sits between the control FSM/datapath and the memory port, and absorbs the LDI/STI/LDB/STB sub-sequences.
// PARAMETERS
//  ADDR_W       16   address width; pointer fetched by indirect ops is mem_rdata[ADDR_W-1:0]
//  DATA_W       16   data width; multiple of 8, >=16
//  BE_W    DATA_W/8  byte lanes (derived, localparam); LANE_W = $clog2(BE_W)
//  TIMEOUT     255   max wait cycles for mem_resp per bus phase; 0 = watchdog disabled
//  INDIRECT_EN   1   1 = RDI/WRI supported; 0 = they complete with err
// PORTS
//  clk              in   1        clock, all state on posedge
//  rst_n            in   1        asynchronous, active-low reset
//  req_valid        in   1        request strobe, sampled only when req_ready=1
//  req_ready        out  1        1 iff state==IDLE
//  req_op           in   3        lc3b_memop: RD=0 WR=1 RDB=2 WRB=3 RDI=4 WRI=5, 6/7 illegal
//  req_addr         in   ADDR_W   byte address (or pointer address for RDI/WRI)
//  req_wdata        in   DATA_W   store data; byte ops use [7:0]
//  done             out  1        one-cycle completion pulse
//  err              out  1        valid with done: timeout / misalign / illegal op
//  rdata            out  DATA_W   load result, held until next accepted request
//  mem_address      out  ADDR_W   bus address
//  mem_read         out  1        bus read strobe
//  mem_write        out  1        bus write strobe
//  mem_byte_enable  out  BE_W     lane enables, valid with mem_write
//  mem_wdata        out  DATA_W   bus write data
//  mem_rdata        in   DATA_W   bus read data, valid with mem_resp
//  mem_resp         in   1        bus completion
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, done=0, err=0, rdata=0, mem_read=mem_write=0, mem_byte_enable=0,
//   mem_address=0, mem_wdata=0, wait counter=0. Mid-transaction reset drops strobes immediately.
//  FSM: IDLE, PTR, PTR_LD, ACCESS, RESP.
//  IDLE: req_valid -> latch op/addr/wdata. Illegal op, RDI/WRI with INDIRECT_EN=0, or word op with
//   addr[LANE_W-1:0]!=0 -> RESP with err=1, no bus activity. Otherwise RDI/WRI -> PTR, else ACCESS.
//  PTR: mem_read=1 at latched addr (word). On mem_resp -> PTR_LD.
//  PTR_LD: addr <= mem_rdata[ADDR_W-1:0]. Misaligned pointer -> RESP err=1, else ACCESS (op as RD/WR).
//  ACCESS: read ops mem_read=1; write ops mem_write=1, all bus outputs constant while waiting.
//   On mem_resp -> RESP. Reads latch rdata here.
//  RESP: done=1 for exactly one cycle, then IDLE. req_ready=0 in RESP.
//  Byte ops: lane = addr[LANE_W-1:0]. WRB: mem_byte_enable = 1<<lane, mem_wdata = {BE_W{wdata[7:0]}}.
//   RDB: rdata = zero-extended byte from lane. Word ops: mem_byte_enable all ones.
//  Strobes are Moore outputs of state. mem_byte_enable=0 whenever mem_write=0.
//  Watchdog: counter clears on entry to PTR/ACCESS and increments each cycle without mem_resp.
//   When count==TIMEOUT and mem_resp=0 -> strobes drop and state goes to RESP with err=1.
//   If mem_resp arrives in that same cycle, mem_resp wins and there is no err.
//  mem_resp in IDLE/PTR_LD/RESP is ignored. req_valid while busy is ignored and not queued.
//  Latency, zero-wait memory (resp in 1st strobe cycle): RD/WR/RDB/WRB done 2 cycles after accept.
//   RDI/WRI take 4 cycles. Error at accept: done on the next cycle.
// STRUCTURE
//  lc3b_types additions: enum lc3b_memop (3 bits, values above); localparam MEMOP_W=3.
//  Sub-module mem_lane_align (combinational): lane decode, byte-enable generation, write-data
//   replication, read-byte extraction. Parameterised by DATA_W.
// TESTING
//  RD addr 0x0040, mem_rdata 0x1234, resp after 3 waits -> done once, rdata=0x1234, err=0, mem_read 4 cycles.
//  WRB addr 0x0041 wdata 0x00AB -> mem_byte_enable=2'b10, mem_wdata=0xABAB, done next cycle after resp.
//  RDI addr 0x0010, ptr read 0x3000, then data 0xBEEF -> second mem_address=0x3000, rdata=0xBEEF.
//  WR addr 0x0003 (misaligned) -> no mem_read/mem_write ever, done+err next cycle. op=7 -> same.
//  TIMEOUT=4, mem_resp held 0 -> strobe 5 cycles, then done+err. Resp on 5th cycle -> err=0.
//  rst_n low during ACCESS wait -> strobes 0 asynchronously; after release, req_ready=1 and a new RD completes.
//  DATA_W=32 RDB addr 0x0006, mem_rdata 0xA1B2C3D4 -> rdata=0x000000B2.

Source files
------------

// File: rtl/mem_seq_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// mem_seq_ctrl_pkg : memory-op encoding, sequencer states and op helpers
// Rev 1.0
// ==========================================================================
package mem_seq_ctrl_pkg;

  localparam int MEMOP_W = 3;

  typedef enum logic [MEMOP_W-1:0] {
    MOP_RD  = 3'd0,
    MOP_WR  = 3'd1,
    MOP_RDB = 3'd2,
    MOP_WRB = 3'd3,
    MOP_RDI = 3'd4,
    MOP_WRI = 3'd5
  } lc3b_memop;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PTR    = 3'd1,
    S_PTR_LD = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } seq_state_t;

  function automatic logic op_legal(input logic [MEMOP_W-1:0] op);
    return op <= MOP_WRI;
  endfunction

  function automatic logic op_is_write(input logic [MEMOP_W-1:0] op);
    return (op == MOP_WR) || (op == MOP_WRB) || (op == MOP_WRI);
  endfunction

  function automatic logic op_is_byte(input logic [MEMOP_W-1:0] op);
    return (op == MOP_RDB) || (op == MOP_WRB);
  endfunction

  function automatic logic op_is_indirect(input logic [MEMOP_W-1:0] op);
    return (op == MOP_RDI) || (op == MOP_WRI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_seq_ctrl_lane.sv
`default_nettype none
// ==========================================================================
// mem_lane_align : byte-lane decode, enables, write replication, read select
// Rev 1.0
// ==========================================================================
module mem_lane_align #(
  parameter int DATA_W = 16
) (
  input  logic [$clog2(DATA_W/8)-1:0] lane,
  input  logic                        byte_op,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rdata_bus,
  output logic [DATA_W/8-1:0]         byte_en,
  output logic [DATA_W-1:0]           wdata_bus,
  output logic [DATA_W-1:0]           rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [7:0] sel_byte;

  assign sel_byte  = rdata_bus[{lane, 3'b000} +: 8];
  assign byte_en   = byte_op ? (BE_W'(1) << lane) : {BE_W{1'b1}};
  assign wdata_bus = byte_op ? {BE_W{wdata[7:0]}} : wdata;
  assign rdata     = byte_op ? {{(DATA_W-8){1'b0}}, sel_byte} : rdata_bus;

endmodule
`default_nettype wire

// File: rtl/mem_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// mem_seq_ctrl : word/byte/indirect memory transaction sequencer with watchdog
// Rev 1.0
// ==========================================================================
module mem_seq_ctrl
  import mem_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT     = 255,
  parameter int INDIRECT_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MEMOP_W-1:0]  req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  seq_state_t         state_q, state_d;
  logic [MEMOP_W-1:0] op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout;
  logic [BE_W-1:0]    lane_be;
  logic [DATA_W-1:0]  lane_wdata;
  logic [DATA_W-1:0]  lane_rdata;

  assign timeout = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!op_legal(req_op) ||
              (op_is_indirect(req_op) && (INDIRECT_EN == 0)) ||
              (!op_is_byte(req_op) && (req_addr[LANE_W-1:0] != '0))) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = op_is_indirect(req_op) ? S_PTR : S_ACCESS;
            err_d   = 1'b0;
          end
        end
      end
      S_PTR: begin
        if (mem_resp) begin
          state_d = S_PTR_LD;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_PTR_LD: begin
        // The fetched pointer is a word address; a misaligned one aborts here.
        if (addr_q[LANE_W-1:0] != '0) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_resp) begin
          state_d = S_RESP;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      err_q <= err_d;
      if (state_q == S_IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Pointer is captured with its response so mem_rdata need not be held.
      if (state_q == S_PTR && mem_resp) addr_q <= mem_rdata[ADDR_W-1:0];
      if (state_q == S_PTR_LD) op_q <= (op_q == MOP_RDI) ? MOP_RD : MOP_WR;
      if (state_q == S_ACCESS && mem_resp && !op_is_write(op_q)) rdata_q <= lane_rdata;
      if ((state_d == state_q) && (state_q == S_PTR || state_q == S_ACCESS))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane (
    .lane      (addr_q[LANE_W-1:0]),
    .byte_op   (op_is_byte(op_q)),
    .wdata     (wdata_q),
    .rdata_bus (mem_rdata),
    .byte_en   (lane_be),
    .wdata_bus (lane_wdata),
    .rdata     (lane_rdata)
  );

  assign req_ready       = (state_q == S_IDLE);
  assign done            = (state_q == S_RESP);
  assign err             = done & err_q;
  assign rdata           = rdata_q;
  assign mem_address     = addr_q;
  assign mem_read        = (state_q == S_PTR) || ((state_q == S_ACCESS) && !op_is_write(op_q));
  assign mem_write       = (state_q == S_ACCESS) && op_is_write(op_q);
  assign mem_byte_enable = mem_write ? lane_be : '0;
  assign mem_wdata       = lane_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_mem_seq_ctrl : directed self-checking bench for mem_seq_ctrl
// Rev 1.0
// ==========================================================================
module tb_mem_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance, short watchdog
  logic        a_req_valid = 1'b0;
  logic        a_req_ready;
  logic [2:0]  a_req_op = '0;
  logic [15:0] a_req_addr = '0;
  logic [15:0] a_req_wdata = '0;
  logic        a_done, a_err;
  logic [15:0] a_rdata, a_mem_address, a_mem_wdata;
  logic        a_mem_read, a_mem_write;
  logic [1:0]  a_mem_byte_enable;
  logic [15:0] a_mem_rdata = '0;
  logic        a_mem_resp = 1'b0;

  // 32-bit instance, indirect ops disabled
  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic [2:0]  b_req_op = '0;
  logic [15:0] b_req_addr = '0;
  logic [31:0] b_req_wdata = '0;
  logic        b_done, b_err;
  logic [31:0] b_rdata, b_mem_wdata;
  logic [15:0] b_mem_address;
  logic        b_mem_read, b_mem_write;
  logic [3:0]  b_mem_byte_enable;
  logic [31:0] b_mem_rdata = 32'hA1B2C3D4;
  logic        b_mem_resp = 1'b0;

  mem_seq_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4), .INDIRECT_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .done(a_done), .err(a_err), .rdata(a_rdata),
    .mem_address(a_mem_address), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_byte_enable(a_mem_byte_enable), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_resp(a_mem_resp)
  );

  mem_seq_ctrl #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(255), .INDIRECT_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .done(b_done), .err(b_err), .rdata(b_rdata),
    .mem_address(b_mem_address), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_byte_enable(b_mem_byte_enable), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory model for instance A: responds after wait_cfg strobe cycles per phase
  int          wait_cfg = 0;
  bit          resp_en  = 1'b1;
  int          strobe_n = 0;
  int          n_rd = 0, n_wr = 0, done_cnt = 0, bad_be = 0, unstable = 0;
  logic [15:0] addr_log[$];
  logic [15:0] data_q[$];
  logic [15:0] first_addr, first_wd;
  logic [1:0]  first_be;

  always @(negedge clk) begin
    if (a_mem_read || a_mem_write) begin
      if (strobe_n == 0) begin
        addr_log.push_back(a_mem_address);
        first_addr = a_mem_address;
        first_be   = a_mem_byte_enable;
        first_wd   = a_mem_wdata;
      end else if (a_mem_address != first_addr || a_mem_byte_enable != first_be ||
                   a_mem_wdata != first_wd) begin
        unstable++;
      end
      if (a_mem_read) n_rd++;
      else            n_wr++;
      if (resp_en && strobe_n == wait_cfg) begin
        a_mem_resp  = 1'b1;
        a_mem_rdata = (data_q.size() > 0) ? data_q.pop_front() : 16'hDEAD;
      end else begin
        a_mem_resp = 1'b0;
      end
      strobe_n++;
    end else begin
      strobe_n   = 0;
      a_mem_resp = 1'b0;
    end
    if (!a_mem_write && a_mem_byte_enable != 2'b00) bad_be++;
    if (a_done) done_cnt++;
  end

  // Zero-wait memory for instance B
  int         b_strobes = 0;
  logic [3:0] b_be_seen = '0;
  logic [31:0] b_wd_seen = '0;
  always @(negedge clk) begin
    b_mem_resp = b_mem_read | b_mem_write;
    if (b_mem_read | b_mem_write) b_strobes++;
    if (b_mem_write) begin
      b_be_seen = b_mem_byte_enable;
      b_wd_seen = b_mem_wdata;
    end
  end

  task automatic do_req(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd,
                        input bit hold, output int lat, output logic err_o);
    @(negedge clk);
    n_rd = 0; n_wr = 0; done_cnt = 0; bad_be = 0; unstable = 0;
    addr_log.delete();
    a_req_valid = 1'b1; a_req_op = op; a_req_addr = addr; a_req_wdata = wd;
    lat = -1; err_o = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!hold) a_req_valid = 1'b0;
      if (a_done) begin
        lat = i; err_o = a_err;
        break;
      end
    end
    a_req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic req_b(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] wd,
                       output int lat, output logic err_o);
    @(negedge clk);
    b_strobes = 0;
    b_req_valid = 1'b1; b_req_op = op; b_req_addr = addr; b_req_wdata = wd;
    lat = -1; err_o = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      b_req_valid = 1'b0;
      if (b_done) begin
        lat = i; err_o = b_err;
        break;
      end
    end
    b_req_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL sim_timeout: got 0x1 expected 0x0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int   lat;
    logic e;

    repeat (3) @(negedge clk);
    check("rst_ready", a_req_ready, 1'b1);
    check("rst_done_err", {a_done, a_err}, 2'b00);
    check("rst_rdata", a_rdata, 16'h0000);
    check("rst_strobes", {a_mem_read, a_mem_write, a_mem_byte_enable}, 4'h0);
    check("rst_addr_wd", {a_mem_address, a_mem_wdata}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // RD with 3 wait cycles
    wait_cfg = 3; data_q.push_back(16'h1234);
    do_req(3'd0, 16'h0040, 16'h0, 1'b0, lat, e);
    check("rd_lat", lat, 5);
    check("rd_err", e, 1'b0);
    check("rd_rdata", a_rdata, 16'h1234);
    check("rd_cycles", {n_rd[7:0], n_wr[7:0]}, 16'h0400);
    check("rd_done_once", done_cnt, 1);
    check("rd_addr", addr_log[0], 16'h0040);
    check("rd_stable", unstable, 0);

    // WRB lane 1
    wait_cfg = 0;
    do_req(3'd3, 16'h0041, 16'h00AB, 1'b0, lat, e);
    check("wrb_lat", lat, 2);
    check("wrb_be", first_be, 2'b10);
    check("wrb_wdata", first_wd, 16'hABAB);
    check("wrb_cycles", {n_rd[7:0], n_wr[7:0]}, 16'h0001);
    check("wrb_be_gated", bad_be, 0);

    // RDI through pointer 0x3000
    data_q.push_back(16'h3000); data_q.push_back(16'hBEEF);
    do_req(3'd4, 16'h0010, 16'h0, 1'b0, lat, e);
    check("rdi_lat", lat, 4);
    check("rdi_ptr_addr", addr_log[0], 16'h0010);
    check("rdi_data_addr", addr_log[1], 16'h3000);
    check("rdi_rdata", a_rdata, 16'hBEEF);
    check("rdi_err", e, 1'b0);

    // Misaligned word write and illegal op: immediate error, no bus activity
    do_req(3'd1, 16'h0003, 16'h5555, 1'b0, lat, e);
    check("mis_lat_err", {lat[7:0], 7'd0, e}, {8'd1, 8'd1});
    check("mis_nobus", n_rd + n_wr, 0);
    check("mis_rdata_held", a_rdata, 16'hBEEF);
    do_req(3'd7, 16'h0040, 16'h0, 1'b0, lat, e);
    check("ill_lat_err", {lat[7:0], 7'd0, e}, {8'd1, 8'd1});
    check("ill_nobus", n_rd + n_wr, 0);

    // Watchdog expiry
    resp_en = 1'b0;
    do_req(3'd0, 16'h0020, 16'h0, 1'b0, lat, e);
    check("to_lat", lat, 6);
    check("to_err", e, 1'b1);
    check("to_strobes", n_rd, 5);
    resp_en = 1'b1;

    // Response on the last allowed cycle wins
    wait_cfg = 4; data_q.push_back(16'h5A5A);
    do_req(3'd0, 16'h0022, 16'h0, 1'b0, lat, e);
    check("to_edge_lat", lat, 6);
    check("to_edge_err", e, 1'b0);
    check("to_edge_rdata", a_rdata, 16'h5A5A);
    check("to_edge_strobes", n_rd, 5);
    wait_cfg = 0;

    // WRI with misaligned pointer
    data_q.push_back(16'h0101);
    do_req(3'd5, 16'h0010, 16'h1111, 1'b0, lat, e);
    check("wri_badptr_lat", lat, 3);
    check("wri_badptr_err", e, 1'b1);
    check("wri_badptr_bus", {n_rd[7:0], n_wr[7:0]}, 16'h0100);

    // RDB lane 1 on 16-bit bus
    data_q.push_back(16'h1234);
    do_req(3'd2, 16'h0043, 16'h0, 1'b0, lat, e);
    check("rdb16_rdata", a_rdata, 16'h0012);

    // Word WR with req_valid held through the whole transaction
    wait_cfg = 2;
    do_req(3'd1, 16'h0050, 16'hCAFE, 1'b1, lat, e);
    check("wr_lat", lat, 4);
    check("wr_be_wd", {first_be, first_wd}, {2'b11, 16'hCAFE});
    check("wr_single", {n_rd[7:0], n_wr[7:0], done_cnt[7:0]}, {8'd0, 8'd3, 8'd1});
    check("wr_stable", unstable, 0);
    wait_cfg = 0;

    // Reset mid-access
    resp_en = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_op = 3'd0; a_req_addr = 16'h0060;
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    check("arst_pre_read", a_mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_strobe_drop", {a_mem_read, a_mem_write, a_req_ready}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    check("arst_ready", a_req_ready, 1'b1);
    data_q.delete(); data_q.push_back(16'h7777);
    do_req(3'd0, 16'h0062, 16'h0, 1'b0, lat, e);
    check("arst_rd_lat", lat, 2);
    check("arst_rd_rdata", a_rdata, 16'h7777);

    // 32-bit instance
    req_b(3'd2, 16'h0006, 32'h0, lat, e);
    check("rdb32_rdata", b_rdata, 32'h000000B2);
    check("rdb32_lat_err", {lat[7:0], 7'd0, e}, {8'd2, 8'd0});
    req_b(3'd3, 16'h0007, 32'h0000005C, lat, e);
    check("wrb32_be", b_be_seen, 4'b1000);
    check("wrb32_wdata", b_wd_seen, 32'h5C5C5C5C);
    req_b(3'd4, 16'h0010, 32'h0, lat, e);
    check("rdi_dis_lat_err", {lat[7:0], 7'd0, e}, {8'd1, 8'd1});
    check("rdi_dis_nobus", b_strobes, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
